// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helper for the binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_ADD     = 3;

  // Number of decimal digits needed to hold 2**bin_w - 1.
  function automatic int bcd_digits_for(input int bin_w);
    longint unsigned max_v;
    longint unsigned pow10;
    int n;
    max_v = (64'd1 << bin_w) - 64'd1;
    pow10 = 64'd10;
    n     = 1;
    for (int i = 0; i < 19; i++) begin
      if (pow10 <= max_v) begin
        n     = n + 1;
        pow10 = pow10 * 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction applied to one BCD digit before each shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(ADJ_THRESH)) begin
      digit_out = digit_in + BCD_DIGIT_W'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble converter, one bit per cycle, valid/ready both sides
// Optional BCD_SIGNED_EN: two's complement input, magnitude converted and sign_out reported.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          busy
`ifdef BCD_SIGNED_EN
  ,
  output logic                          sign_out
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < bcd_digits_for(BIN_W)) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BIN_W-1:0]   bin_mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The top bit falls off the shift; the BCD width is sized so it is always zero.
  assign shifted = {bcd_adj, bin_q} << 1;

`ifdef BCD_SIGNED_EN
  logic sign_q, sign_d;
  // -2**(BIN_W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign bin_mag  = bin_in[BIN_W-1] ? (~bin_in) + BIN_W'(1) : bin_in;
  assign sign_out = sign_q;
`else
  assign bin_mag  = bin_in;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bcd_out_d = bcd_out_q;
`ifdef BCD_SIGNED_EN
    sign_d    = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          bin_d   = bin_mag;
          bcd_d   = '0;
          count_d = '0;
`ifdef BCD_SIGNED_EN
          sign_d  = bin_in[BIN_W-1];
`endif
        end
      end
      SHIFT: begin
        bcd_d   = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_d   = shifted[BIN_W-1:0];
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(BIN_W - 1)) begin
          state_d   = DONE;
          bcd_out_d = shifted[BCD_W+BIN_W-1:BIN_W];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      bcd_out_q <= '0;
`ifdef BCD_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bcd_out_q <= bcd_out_d;
`ifdef BCD_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq with a decimal reference model
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int N_RAND = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  bin_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] bcd_out;
  logic        busy;
`ifdef BCD_SIGNED_EN
  logic        sign_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
`ifdef BCD_SIGNED_EN
    ,
    .sign_out  (sign_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned mag_of(input int unsigned raw);
`ifdef BCD_SIGNED_EN
    if (raw >= 128) return 256 - raw;
`endif
    return raw;
  endfunction

  function automatic logic sign_of(input int unsigned raw);
`ifdef BCD_SIGNED_EN
    return raw >= 128;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] bcd_ref(input int unsigned raw);
    int unsigned m;
    logic [11:0] r;
    m = mag_of(raw);
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present v, check the 8-cycle latency and result, then complete the output handshake.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd, input logic exp_sign);
    int cyc;
    in_valid = 1'b1;
    bin_in   = v;
    step();
    in_valid = 1'b0;
    check("accept_busy", busy, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("latency", cyc, BIN_W);
    check("bcd_value", bcd_out, exp_bcd);
`ifdef BCD_SIGNED_EN
    check("sign_value", sign_out, exp_sign);
`else
    check("sign_model", sign_of(v), exp_sign);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [11:0] held;
    logic        p_acc, p_out;
    logic [11:0] p_bcd;
    logic        p_sign;
    int unsigned cur_val;
    int unsigned exp_raw;
    int unsigned q[$];
    int n_acc, n_out, cyc, last_out;
    logic [7:0] vals[5];
    logic [11:0] exps[5];

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bcd", bcd_out, 12'h000);

`ifndef BCD_SIGNED_EN
    convert(8'd255, 12'h255, 1'b0);
    vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100};
    exps = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
    for (int i = 0; i < 5; i++) convert(vals[i], exps[i], 1'b0);
`else
    convert(8'hF6, 12'h010, 1'b1);
    convert(8'h80, 12'h128, 1'b1);
    convert(8'h7F, 12'h127, 1'b0);
`endif

    // Backpressure: result held for 20 cycles while a new request is offered and ignored.
    in_valid = 1'b1;
    bin_in   = 8'd77;
    step();
    bin_in   = 8'd5;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    held = bcd_out;
    check("bp_first", held, 12'h077);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_bcd_stable", bcd_out, 12'h077);
      check("bp_valid_held", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_not_latched", busy, 1'b0);

    // Reset during the fourth SHIFT cycle discards the conversion.
    in_valid = 1'b1;
    bin_in   = 8'd173;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_bcd", bcd_out, 12'h000);
    convert(8'd42, 12'h042, 1'b0);

    // Back-to-back stream with out_ready tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cur_val   = $urandom_range(0, 255);
    bin_in    = 8'(cur_val);
    p_acc  = in_ready && in_valid;
    p_out  = out_valid && out_ready;
    p_bcd  = bcd_out;
    p_sign = 1'b0;
    n_acc = 0;
    n_out = 0;
    cyc = 0;
    last_out = 0;
    while (n_out < N_RAND && cyc < 12000) begin
      step();
      cyc++;
      if (p_acc) begin
        q.push_back(cur_val);
        n_acc++;
        cur_val = $urandom_range(0, 255);
      end
      if (p_out) begin
        if (q.size() == 0) begin
          check("stream_dup", 1, 0);
        end else begin
          exp_raw = q.pop_front();
          check("stream_bcd", p_bcd, bcd_ref(exp_raw));
`ifdef BCD_SIGNED_EN
          check("stream_sign", p_sign, sign_of(exp_raw));
`endif
        end
        if (n_out > 0) check("stream_spacing", cyc - last_out, BIN_W + 2);
        last_out = cyc;
        n_out++;
      end
      in_valid = (n_acc < N_RAND);
      bin_in   = 8'(cur_val);
      p_acc  = in_ready && in_valid;
      p_out  = out_valid && out_ready;
      p_bcd  = bcd_out;
`ifdef BCD_SIGNED_EN
      p_sign = sign_out;
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_count", n_out, N_RAND);
    check("stream_accepts", n_acc, N_RAND);
    check("stream_leftover", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
